serial_rshift: RTL and testbench

SERIAL_RSHIFT -- requirements
Module: serial_rshift

---
 rtl/serial_rshift.sv | 94 +++++++++
 tb/tb_serial_rshift.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_rshift.sv
// Multi-cycle serial right shifter: one bit per clock, logical or arithmetic.
// Define SRS_ARITH_EN to honour the arith port; otherwise every shift is logical.
module serial_rshift (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clr,
    input  logic [31:0] in,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] count;
    logic       mode;
    logic       arith_sel;
    logic       fill;

`ifdef SRS_ARITH_EN
    assign arith_sel = arith;
`else
    logic unused_arith;
    assign unused_arith = arith;
    assign arith_sel    = 1'b0;
`endif

    // mode is only ever set when arithmetic shifting is built in
    assign fill = mode & out[31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
            out   <= '0;
            count <= '0;
            mode  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (clr) begin
            // abort wins over any pending start; out keeps its partial value
            state <= StIdle;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        out   <= in;
                        count <= shamt;
                        mode  <= arith_sel;
                        if (shamt != 5'd0) begin
                            state <= StShift;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                StShift: begin
                    out   <= {fill, out[31:1]};
                    count <= count - 5'd1;
                    // count never reaches zero while in StShift, so no wrap
                    if (count <= 5'd1) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rshift.sv
// Scoreboard bench for serial_rshift: stimulus pushes expected results,
// a negedge monitor pops and compares result, busy length and done timing.
module tb_serial_rshift;

`ifdef SRS_ARITH_EN
    localparam bit ArithEn = 1'b1;
`else
    localparam bit ArithEn = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        clr;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] out;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] res;
        int          busy_n;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   busy_run   = 0;

    serial_rshift dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .clr   (clr),
        .in    (in),
        .shamt (shamt),
        .arith (arith),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 with out=%h, expected no done", out);
            end else begin
                e = sb.pop_front();
                check("result", out, e.res);
                check("busy_cycles", busy_run, e.busy_n);
                check("done_cycle", cyc, e.cyc);
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    // Called at a negedge; start is high across exactly one rising edge.
    task automatic op(input logic [31:0] d, input logic [4:0] s, input logic a,
                      input bit push, input logic [31:0] e);
        exp_t x;
        start = 1'b1;
        in    = d;
        shamt = s;
        arith = a;
        if (push) begin
            x.res    = e;
            x.busy_n = int'(s);
            x.cyc    = cyc + 1 + int'(s);
            sb.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'd0, busy | done}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        clr   = 1'b0;
        in    = '0;
        shamt = '0;
        arith = 1'b0;
        #1;
        check("reset_out", out, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // basic logical and arithmetic shift by 4
        op(32'h8000_00F0, 5'd4, 1'b0, 1'b1, 32'h0800_000F);
        wait_idle();
        op(32'h8000_00F0, 5'd4, 1'b1, 1'b1, ArithEn ? 32'hF800_000F : 32'h0800_000F);
        wait_idle();
        // zero shift goes straight to done, busy never rises
        op(32'h1234_5678, 5'd0, 1'b0, 1'b1, 32'h1234_5678);
        wait_idle();
        check("idle_hold", out, 32'h1234_5678);

        // start re-pulsed during SHIFT is ignored
        op(32'hFFFF_0000, 5'd16, 1'b0, 1'b1, 32'h0000_FFFF);
        repeat (2) @(negedge clk);
        start = 1'b1;
        in    = 32'hDEAD_BEEF;
        shamt = 5'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // full-width arithmetic shift, then back-to-back start in the DONE cycle
        op(32'h8000_0000, 5'd31, 1'b1, 1'b1, ArithEn ? 32'hFFFF_FFFF : 32'h0000_0001);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        op(32'h0000_0002, 5'd1, 1'b0, 1'b1, 32'h0000_0001);
        wait_idle();
        op(32'hF000_0001, 5'd1, 1'b1, 1'b1, ArithEn ? 32'hF800_0000 : 32'h7800_0000);
        wait_idle();

        // clr sampled at edge k+2 of a 10-bit shift: one shift done, then abort
        op(32'hFFFF_FFFF, 5'd10, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_done", {31'd0, done}, 32'd0);
        check("clr_out", out, 32'h7FFF_FFFF);
        // clr with start: start dropped
        clr   = 1'b1;
        start = 1'b1;
        in    = 32'h0000_0055;
        shamt = 5'd3;
        @(negedge clk);
        clr   = 1'b0;
        start = 1'b0;
        check("clr_start_busy", {31'd0, busy}, 32'd0);
        check("clr_start_out", out, 32'h7FFF_FFFF);
        repeat (15) @(negedge clk);

        // asynchronous reset mid-shift discards the operation
        op(32'hABCD_0000, 5'd8, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_out", out, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        #1 reset = 1'b0;
        repeat (15) @(negedge clk);

        // first operation after reset release
        op(32'h0000_0100, 5'd8, 1'b0, 1'b1, 32'h0000_0001);
        wait_idle();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
